// File: rtl/vignette_blend_axis.sv
// Vignette filter on an AXI4-Stream video path: blends each pixel toward a background
// colour by its squared distance from a programmable centre, in a 5-stage stallable pipeline.
module vignette_blend_axis #(
  parameter int COLOR_WIDTH = 8,
  parameter int CHANNELS    = 3,
  parameter int COORD_WIDTH = 11,
  parameter int MUL_BITS    = 8,
  parameter int X_SHIFT     = 1
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [1:0]                      mode,
  input  logic [4:0]                      strength,
  input  logic [COORD_WIDTH-1:0]          x_mid,
  input  logic [COORD_WIDTH-1:0]          y_mid,
  input  logic [CHANNELS*COLOR_WIDTH-1:0] avg_color,
  input  logic [CHANNELS*COLOR_WIDTH-1:0] const_color,
  input  logic [CHANNELS*COLOR_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tuser,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [CHANNELS*COLOR_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);
  localparam int DW  = CHANNELS * COLOR_WIDTH;
  localparam int SQW = 2 * COORD_WIDTH;
  localparam int R2W = SQW + 1;
  localparam int WW  = MUL_BITS + 1;
  localparam int PW  = COLOR_WIDTH + MUL_BITS + 1;
  localparam logic [WW-1:0]  FULL_W  = WW'(2 ** MUL_BITS);
  localparam logic [R2W-1:0] FULL_R2 = R2W'(2 ** MUL_BITS);

  logic w_en, w_acc;
  assign w_en          = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = w_en && aresetn;
  assign w_acc         = s_axis_tvalid && s_axis_tready;

  // Coordinates and configuration as seen by the current input beat (SOF overrides both)
  logic [COORD_WIDTH-1:0] r_x, r_y, w_bx, w_by;
  logic [1:0]             r_mode, w_mode;
  logic [4:0]             r_str, w_str;
  logic [COORD_WIDTH-1:0] r_xmid, r_ymid, w_xmid, w_ymid;
  logic [DW-1:0]          r_avg, r_const, w_bg;

  assign w_bx   = s_axis_tuser ? '0 : r_x;
  assign w_by   = s_axis_tuser ? '0 : r_y;
  assign w_mode = s_axis_tuser ? mode : r_mode;
  assign w_str  = s_axis_tuser ? strength : r_str;
  assign w_xmid = s_axis_tuser ? x_mid : r_xmid;
  assign w_ymid = s_axis_tuser ? y_mid : r_ymid;
  assign w_bg   = (w_mode == 2'd1) ? '0 :
                  (w_mode == 2'd2) ? (s_axis_tuser ? avg_color : r_avg) :
                                     (s_axis_tuser ? const_color : r_const);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_x <= '0; r_y <= '0; r_mode <= '0; r_str <= '0;
      r_xmid <= '0; r_ymid <= '0; r_avg <= '0; r_const <= '0;
    end else if (w_acc) begin
      if (s_axis_tuser) begin
        r_mode <= mode; r_str <= strength; r_xmid <= x_mid; r_ymid <= y_mid;
        r_avg <= avg_color; r_const <= const_color;
      end
      if (s_axis_tlast) begin
        r_x <= '0;
        r_y <= w_by + 1'b1;
      end else begin
        r_x <= w_bx + 1'b1;
        r_y <= w_by;
      end
    end
  end

  logic [COORD_WIDTH-1:0] w_dxa, w_dya;
  assign w_dxa = (w_bx >= w_xmid) ? (w_bx - w_xmid) : (w_xmid - w_bx);
  assign w_dya = (w_by >= w_ymid) ? (w_by - w_ymid) : (w_ymid - w_by);

  logic                   r1_v, r1_u, r1_l, r2_v, r2_u, r2_l, r3_v, r3_u, r3_l, r4_v, r4_u, r4_l;
  logic [DW-1:0]          r1_pix, r2_pix, r3_pix, r4_pix, r1_bg, r2_bg, r3_bg;
  logic [1:0]             r1_mode, r2_mode, r3_mode, r4_mode;
  logic [4:0]             r1_str, r2_str;
  logic [COORD_WIDTH-1:0] r1_dx, r1_dy;
  logic [SQW-1:0]         r2_dx2, r2_dy2;
  logic [WW-1:0]          r3_d, r3_w;

  logic [R2W-1:0] w_r2, w_sh;
  logic [WW-1:0]  w_d;
  assign w_r2 = R2W'(r2_dx2) + R2W'(r2_dy2);
  assign w_sh = w_r2 >> r2_str;
  assign w_d  = (w_sh > FULL_R2) ? FULL_W : w_sh[WW-1:0];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      {r1_v, r1_u, r1_l, r2_v, r2_u, r2_l, r3_v, r3_u, r3_l, r4_v, r4_u, r4_l} <= '0;
      r1_pix <= '0; r2_pix <= '0; r3_pix <= '0; r4_pix <= '0;
      r1_bg <= '0; r2_bg <= '0; r3_bg <= '0;
      r1_mode <= '0; r2_mode <= '0; r3_mode <= '0; r4_mode <= '0;
      r1_str <= '0; r2_str <= '0; r1_dx <= '0; r1_dy <= '0;
      r2_dx2 <= '0; r2_dy2 <= '0; r3_d <= '0; r3_w <= '0;
    end else if (w_en) begin
      r1_v <= s_axis_tvalid; r1_u <= s_axis_tuser; r1_l <= s_axis_tlast;
      r1_pix <= s_axis_tdata; r1_bg <= w_bg; r1_mode <= w_mode; r1_str <= w_str;
      r1_dx <= w_dxa >> X_SHIFT;
      r1_dy <= w_dya;
      r2_v <= r1_v; r2_u <= r1_u; r2_l <= r1_l;
      r2_pix <= r1_pix; r2_bg <= r1_bg; r2_mode <= r1_mode; r2_str <= r1_str;
      r2_dx2 <= SQW'(r1_dx) * SQW'(r1_dx);
      r2_dy2 <= SQW'(r1_dy) * SQW'(r1_dy);
      r3_v <= r2_v; r3_u <= r2_u; r3_l <= r2_l;
      r3_pix <= r2_pix; r3_bg <= r2_bg; r3_mode <= r2_mode;
      r3_d <= w_d;
      r3_w <= FULL_W - w_d;
      r4_v <= r3_v; r4_u <= r3_u; r4_l <= r3_l;
      r4_pix <= r3_pix; r4_mode <= r3_mode;
    end
  end

  logic [DW-1:0] w_blend;
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam logic [COLOR_WIDTH+1:0] CMAX = {2'b00, {COLOR_WIDTH{1'b1}}};
      logic [PW-1:0]          r_p, r_q;
      logic [PW:0]            w_sum;
      logic [COLOR_WIDTH+1:0] w_scaled;

      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          r_p <= '0;
          r_q <= '0;
        end else if (w_en) begin
          r_p <= PW'(r3_pix[gi*COLOR_WIDTH +: COLOR_WIDTH]) * PW'(r3_w);
          r_q <= PW'(r3_bg[gi*COLOR_WIDTH +: COLOR_WIDTH]) * PW'(r3_d);
        end
      end

      assign w_sum    = {1'b0, r_p} + {1'b0, r_q};
      assign w_scaled = w_sum[PW:MUL_BITS];
      assign w_blend[gi*COLOR_WIDTH +: COLOR_WIDTH] =
        (w_scaled > CMAX) ? {COLOR_WIDTH{1'b1}} : w_scaled[COLOR_WIDTH-1:0];
    end
  endgenerate

  // Output stage doubles as the AXI source register, so it holds while stalled
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata <= '0; m_axis_tvalid <= 1'b0; m_axis_tuser <= 1'b0; m_axis_tlast <= 1'b0;
    end else if (w_en) begin
      m_axis_tdata  <= (r4_mode == 2'd0) ? r4_pix : w_blend;
      m_axis_tvalid <= r4_v;
      m_axis_tuser  <= r4_u;
      m_axis_tlast  <= r4_l;
    end
  end
endmodule
